// File: rtl/uartb_rx_packer_if.sv
// Byte intake from the UART core and word output toward the CPU/bus side.
// master = packer view, slave = core + consumer view.
interface uartb_rx_packer_if;
    logic [7:0]  rxdata;
    logic        rxdv;
    logic        rxrd;
    logic [31:0] wdata;
    logic [2:0]  wlen;
    logic        wvalid;
    logic        wready;

    modport master (
        input  rxdata, rxdv, wready,
        output rxrd, wdata, wlen, wvalid
    );

    modport slave (
        output rxdata, rxdv, wready,
        input  rxrd, wdata, wlen, wvalid
    );
endinterface

// File: rtl/uartb_rx_packer.sv
// Packs received UART bytes LSB-first into 32-bit words.
// Each word is either a single byte or a burst of up to 4 bytes, with an idle flush.
module uartb_rx_packer #(
    parameter int TIMEOUT   = 2000,
    parameter int TIMEOUT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    uartb_rx_packer_if.master  bus,
    output logic [15:0]        nwords
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam int LANE_W    = $clog2(NUM_LANES);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t                             state;
    logic [NUM_LANES-1:0][VEC_W-1:0]    lanes;
    logic [NUM_LANES-1:0][VEC_W-1:0]    partial;
    logic [NUM_LANES-1:0][VEC_W-1:0]    full;
    logic [LANE_W-1:0]                  lane;
    logic [TIMEOUT_W-1:0]               idle;
    logic                               cap;

    // DV is still high during the rd cycle, so the pending strobe masks it.
    assign cap = (state != HOLD) && bus.rxdv && !bus.rxrd;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign partial[g] = (LANE_W'(g) < lane) ? lanes[g] : '0;
        if (g == NUM_LANES - 1) begin : g_last
            assign full[g] = bus.rxdata;
        end else begin : g_held
            assign full[g] = lanes[g];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lanes      <= '0;
            lane       <= '0;
            idle       <= '0;
            nwords     <= '0;
            bus.rxrd   <= 1'b0;
            bus.wdata  <= '0;
            bus.wlen   <= '0;
            bus.wvalid <= 1'b0;
        end else begin
            bus.rxrd <= cap;
            if (cap) begin
                lanes[lane] <= bus.rxdata;
                idle        <= '0;
            end
            case (state)
                IDLE: begin
                    // mode only matters here: it picks the word type at byte0
                    if (cap) begin
                        if (!mode) begin
                            bus.wdata  <= 32'(bus.rxdata);
                            bus.wlen   <= 3'd1;
                            bus.wvalid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            lane  <= LANE_W'(1);
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (cap) begin
                        if (lane == LANE_W'(NUM_LANES - 1)) begin
                            bus.wdata  <= full;
                            bus.wlen   <= 3'(NUM_LANES);
                            bus.wvalid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end else begin
                        idle <= idle + 1'b1;
                        if (idle == TIMEOUT_W'(TIMEOUT - 1)) begin
                            bus.wdata  <= partial;
                            bus.wlen   <= 3'(lane);
                            bus.wvalid <= 1'b1;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.wready) begin
                        bus.wvalid <= 1'b0;
                        lane       <= '0;
                        idle       <= '0;
                        nwords     <= nwords + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uartb_rx_packer.sv
// Self-checking bench for uartb_rx_packer: directed scenarios plus a randomized
// byte stream checked against a word-level expectation queue.
module tb_uartb_rx_packer;
    localparam int TO = 24;
    localparam int NR = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [15:0] nwords;

    uartb_rx_packer_if bus();

    uartb_rx_packer #(.TIMEOUT(TO), .TIMEOUT_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .bus    (bus.master),
        .nwords (nwords)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int dbl_cnt = 0;
    logic rd_q = 1'b0;

    always @(negedge clk) begin
        if (bus.rxrd) rd_cnt++;
        if (bus.rxrd && rd_q) dbl_cnt++;
        rd_q = bus.rxrd;
    end

    // random-test plan, shared by sender and receiver branches
    logic        rmode [NR];
    int          rn    [NR];
    logic [7:0]  rb    [NR][4];
    logic [31:0] exp_d [$];
    logic [2:0]  exp_l [$];

    // core model: present a byte, hold DV through the rd cycle (+extra), then clear
    task automatic send_byte(input logic [7:0] b, input logic m, input int extra, output bit ok);
        bus.rxdata = b;
        bus.rxdv   = 1'b1;
        mode       = m;
        ok         = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.rxrd) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (1 + extra) @(negedge clk);
        bus.rxdv = 1'b0;
    endtask

    task automatic wait_wvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (bus.wvalid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic take_word();
        bus.wready = 1'b1;
        @(negedge clk);
        bus.wready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rxdv = 1'b1;
        bus.rxdata = 8'hEE;
        bus.wready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.rxrd !== 1'b0) begin errors++; $display("FAIL reset_rxrd: got %b want 0", bus.rxrd); end
        checks++; if (bus.wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b want 0", bus.wvalid); end
        checks++; if (bus.wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.wdata); end
        checks++; if (bus.wlen !== 3'd0) begin errors++; $display("FAIL reset_wlen: got %0d want 0", bus.wlen); end
        checks++; if (nwords !== 16'd0) begin errors++; $display("FAIL reset_nwords: got %0d want 0", nwords); end
        bus.rxdv = 1'b0;
        bus.wready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL reset_no_rd: got %0d want 0", rd_cnt); end
    endtask

    task automatic test_mode0();
        bit ok;
        int r0 = rd_cnt;
        send_byte(8'h41, 1'b0, 0, ok);
        wait_wvalid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mode0_wvalid: got timeout want wvalid"); end
        checks++; if (bus.wdata !== 32'h00000041) begin errors++; $display("FAIL mode0_wdata: got %h want 00000041", bus.wdata); end
        checks++; if (bus.wlen !== 3'd1) begin errors++; $display("FAIL mode0_wlen: got %0d want 1", bus.wlen); end
        checks++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL mode0_rdpulses: got %0d want 1", rd_cnt - r0); end
        take_word();
        checks++; if (bus.wvalid !== 1'b0) begin errors++; $display("FAIL mode0_wvalid_clr: got %b want 0", bus.wvalid); end
        checks++; if (nwords !== 16'd1) begin errors++; $display("FAIL mode0_nwords: got %0d want 1", nwords); end
    endtask

    task automatic test_burst();
        bit ok;
        int r0 = rd_cnt;
        for (int i = 0; i < 4; i++) send_byte(8'h41 + 8'(i), 1'b1, 0, ok);
        wait_wvalid(ok);
        checks++; if (bus.wdata !== 32'h44434241) begin errors++; $display("FAIL burst_wdata: got %h want 44434241", bus.wdata); end
        checks++; if (bus.wlen !== 3'd4) begin errors++; $display("FAIL burst_wlen: got %0d want 4", bus.wlen); end
        checks++; if (rd_cnt - r0 !== 4) begin errors++; $display("FAIL burst_rdpulses: got %0d want 4", rd_cnt - r0); end
        checks++; if (dbl_cnt !== 0) begin errors++; $display("FAIL burst_rd_single: got %0d long pulses want 0", dbl_cnt); end
        take_word();
        checks++; if (nwords !== 16'd2) begin errors++; $display("FAIL burst_nwords: got %0d want 2", nwords); end
    endtask

    task automatic test_timeout();
        bit ok;
        int cyc;
        send_byte(8'h5A, 1'b1, 0, ok);
        send_byte(8'h5B, 1'b1, 0, ok);
        // second capture's rd was seen one negedge ago
        cyc = 1;
        while (!bus.wvalid && cyc < TO + 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc !== TO) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", cyc, TO); end
        checks++; if (bus.wdata !== 32'h00005B5A) begin errors++; $display("FAIL timeout_wdata: got %h want 00005B5A", bus.wdata); end
        checks++; if (bus.wlen !== 3'd2) begin errors++; $display("FAIL timeout_wlen: got %0d want 2", bus.wlen); end
        take_word();
    endtask

    task automatic test_backpressure();
        bit ok, ok2;
        int r0;
        bus.wready = 1'b0;
        send_byte(8'h10, 1'b0, 0, ok);
        r0 = rd_cnt;
        fork
            send_byte(8'h20, 1'b0, 0, ok2);
            begin
                repeat (30) @(negedge clk);
                checks++; if (rd_cnt !== r0) begin errors++; $display("FAIL bp_no_rd: got %0d pulses want 0", rd_cnt - r0); end
                checks++; if (bus.wdata !== 32'h10 || bus.wvalid !== 1'b1) begin errors++; $display("FAIL bp_hold_word: got %h/%b want 00000010/1", bus.wdata, bus.wvalid); end
                take_word();
                wait_wvalid(ok);
                checks++; if (!ok || bus.wdata !== 32'h20 || bus.wlen !== 3'd1) begin errors++; $display("FAIL bp_second_word: got %h len %0d want 00000020 len 1", bus.wdata, bus.wlen); end
                take_word();
            end
        join
        checks++; if (!ok2) begin errors++; $display("FAIL bp_second_ack: got timeout want rd"); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_byte(8'h01, 1'b1, 0, ok);
        send_byte(8'h02, 1'b1, 0, ok);
        #5 rst = 1'b1;
        #1;
        checks++; if (bus.wvalid !== 1'b0 || bus.wlen !== 3'd0 || bus.rxrd !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got v%b l%0d rd%b want 0", bus.wvalid, bus.wlen, bus.rxrd); end
        checks++; if (bus.wdata !== 32'h0 || nwords !== 16'd0) begin errors++; $display("FAIL rstmid_data: got %h n%0d want 0", bus.wdata, nwords); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) send_byte(8'(i * 8'h11), 1'b1, 0, ok);
        wait_wvalid(ok);
        checks++; if (bus.wdata !== 32'h44332211 || bus.wlen !== 3'd4) begin errors++; $display("FAIL rstmid_word: got %h len %0d want 44332211 len 4", bus.wdata, bus.wlen); end
        take_word();
        checks++; if (nwords !== 16'd1) begin errors++; $display("FAIL rstmid_nwords: got %0d want 1", nwords); end
    endtask

    task automatic test_mode_switch();
        bit ok;
        send_byte(8'hA0, 1'b1, 0, ok);
        for (int i = 1; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b0, 0, ok);
        wait_wvalid(ok);
        checks++; if (bus.wdata !== 32'hA3A2A1A0 || bus.wlen !== 3'd4) begin errors++; $display("FAIL modesw_burst: got %h len %0d want A3A2A1A0 len 4", bus.wdata, bus.wlen); end
        take_word();
        send_byte(8'hB0, 1'b0, 0, ok);
        wait_wvalid(ok);
        checks++; if (bus.wdata !== 32'h000000B0 || bus.wlen !== 3'd1) begin errors++; $display("FAIL modesw_single: got %h len %0d want 000000B0 len 1", bus.wdata, bus.wlen); end
        take_word();
    endtask

    task automatic test_slow_clear();
        bit ok;
        int r0 = rd_cnt;
        send_byte(8'hC3, 1'b0, 3, ok);
        checks++; if (bus.wvalid !== 1'b1 || bus.wdata !== 32'hC3) begin errors++; $display("FAIL slow_word: got %h/%b want 000000C3/1", bus.wdata, bus.wvalid); end
        take_word();
        repeat (4) @(negedge clk);
        checks++; if (rd_cnt - r0 !== 1 || bus.wvalid !== 1'b0) begin errors++; $display("FAIL slow_single_capture: got %0d rd, wvalid %b want 1 rd, wvalid 0", rd_cnt - r0, bus.wvalid); end
    endtask

    task automatic test_random();
        logic [15:0] n0 = nwords;
        for (int w = 0; w < NR; w++) begin
            logic [31:0] d = '0;
            rmode[w] = 1'($urandom_range(0, 1));
            rn[w]    = rmode[w] ? $urandom_range(1, 4) : 1;
            for (int i = 0; i < 4; i++) rb[w][i] = 8'($urandom);
            for (int i = 0; i < rn[w]; i++) d = d | (32'(rb[w][i]) << (8 * i));
            exp_d.push_back(d);
            exp_l.push_back(3'(rn[w]));
        end
        fork
            begin : sender
                bit ok;
                for (int w = 0; w < NR; w++) begin
                    for (int i = 0; i < rn[w]; i++) begin
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        send_byte(rb[w][i], (i == 0) ? rmode[w] : 1'($urandom_range(0, 1)), 0, ok);
                        checks++; if (!ok) begin errors++; $display("FAIL rand_ack w%0d b%0d: got timeout want rd", w, i); end
                    end
                    if (rmode[w] && rn[w] < 4) repeat (TO + 2) @(negedge clk);
                end
            end
            begin : receiver
                int got = 0;
                int budget = 40000;
                while (got < NR && budget > 0) begin
                    if (bus.wvalid && $urandom_range(0, 2) != 0) begin
                        checks++;
                        if (exp_d.size() == 0) begin
                            errors++; $display("FAIL rand_extra: got %h want no word", bus.wdata);
                        end else if (bus.wdata !== exp_d[0] || bus.wlen !== exp_l[0]) begin
                            errors++; $display("FAIL rand_word%0d: got %h len %0d want %h len %0d", got, bus.wdata, bus.wlen, exp_d[0], exp_l[0]);
                        end
                        if (exp_d.size() != 0) begin
                            void'(exp_d.pop_front());
                            void'(exp_l.pop_front());
                        end
                        got++;
                        take_word();
                    end else begin
                        @(negedge clk);
                    end
                    budget--;
                end
                checks++; if (got !== NR) begin errors++; $display("FAIL rand_count: got %0d words want %0d", got, NR); end
            end
        join
        checks++; if (nwords !== 16'(n0 + NR)) begin errors++; $display("FAIL rand_nwords: got %0d want %0d", nwords, 16'(n0 + NR)); end
    endtask

    initial begin
        rst = 1'b1;
        mode = 1'b0;
        bus.rxdata = 8'h00;
        bus.rxdv = 1'b0;
        bus.wready = 1'b0;
        @(negedge clk);
        test_reset();
        test_mode0();
        test_burst();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_mode_switch();
        test_slow_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
